// File: rtl/dmem_responder.sv
// Data-memory responder: slave end of the MEM-stage load/store port.
// Serializes one request at a time, with optional wait states before the response.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);

    localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    localparam logic [3:0] WaitInit = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [31:0] mem [DEPTH_WORDS];

    logic [1:0]  stateQ, stateD;
    logic [3:0]  cntQ, cntD;
    logic        weQ;
    logic [31:0] addrQ;
    logic [1:0]  sizeQ;
    logic [31:0] wdataQ;
    logic [31:0] rdataQ;
    logic        readyQ;
    logic        errQ;

    logic        enterResp;
    logic        curWe;
    logic [31:0] curAddr;
    logic [1:0]  curSize;
    logic [31:0] curWdata;
    logic        isWord, isHalf;
    logic [29:0] wordIdx;
    logic [IdxW-1:0] memIdx;
    logic        accErr;
    logic [31:0] rdWord, shifted, loadVal;
    logic [3:0]  byteMask;
    logic [31:0] laneData;

    // Select live inputs in IDLE (zero-wait accept) and latched fields otherwise.
    always_comb begin
        curWe    = (stateQ == StIdle) ? we    : weQ;
        curAddr  = (stateQ == StIdle) ? addr  : addrQ;
        curSize  = (stateQ == StIdle) ? size  : sizeQ;
        curWdata = (stateQ == StIdle) ? wdata : wdataQ;
        isHalf   = (curSize == 2'd1);
        isWord   = (curSize == 2'd0) || (curSize == 2'd3);
        wordIdx  = curAddr[31:2];
        memIdx   = wordIdx[IdxW-1:0];
        accErr   = (isHalf && curAddr[0]) || (isWord && (curAddr[1:0] != 2'd0)) ||
                   (wordIdx >= 30'(DEPTH_WORDS));
        rdWord   = mem[memIdx];
        shifted  = rdWord >> {curAddr[1:0], 3'b000};
        if (isWord) begin
            loadVal  = shifted;
            byteMask = 4'b1111;
            laneData = curWdata;
        end else if (isHalf) begin
            loadVal  = {16'h0000, shifted[15:0]};
            byteMask = curAddr[1] ? 4'b1100 : 4'b0011;
            laneData = {2{curWdata[15:0]}};
        end else begin
            loadVal  = {24'h000000, shifted[7:0]};
            byteMask = 4'b0001 << curAddr[1:0];
            laneData = {4{curWdata[7:0]}};
        end
    end

    // Next-state and wait counter.
    always_comb begin
        stateD    = stateQ;
        cntD      = cntQ;
        enterResp = 1'b0;
        case (stateQ)
            StIdle: begin
                if (req) begin
                    if (WAIT_STATES > 0) begin
                        stateD = StWait;
                        cntD   = WaitInit;
                    end else begin
                        stateD    = StResp;
                        enterResp = 1'b1;
                    end
                end
            end
            StWait: begin
                if (cntQ == 4'd0) begin
                    stateD    = StResp;
                    enterResp = 1'b1;
                end else begin
                    cntD = cntQ - 4'd1;
                end
            end
            StResp:  stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    // State, latched request fields and registered response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ <= StIdle;
            cntQ   <= 4'd0;
            weQ    <= 1'b0;
            addrQ  <= 32'd0;
            sizeQ  <= 2'd0;
            wdataQ <= 32'd0;
            rdataQ <= 32'd0;
            readyQ <= 1'b0;
            errQ   <= 1'b0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
            if (stateQ == StIdle && req) begin
                weQ    <= we;
                addrQ  <= addr;
                sizeQ  <= size;
                wdataQ <= wdata;
            end
            readyQ <= enterResp;
            errQ   <= enterResp && accErr;
            if (enterResp) begin
                rdataQ <= (curWe || accErr) ? 32'd0 : loadVal;
            end
        end
    end

    // Store commit on the edge leaving RESP; only masked lanes are written.
    always_ff @(posedge clk) begin
        if (!reset && stateQ == StResp && weQ && !accErr) begin
            for (int b = 0; b < 4; b++) begin
                if (byteMask[b]) begin
                    mem[memIdx][8*b +: 8] <= laneData[8*b +: 8];
                end
            end
        end
    end

    assign rdata = rdataQ;
    assign ready = readyQ;
    assign err   = errQ;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (0 and 3 wait states) against a byte-addressed model.
module tb_dmem_responder;

    localparam int unsigned Depth = 64;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        req   [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [1:0]  size  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        ready [2];
    logic        err   [2];

    dmem_responder #(.DEPTH_WORDS(Depth), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .req(req[0]), .we(we[0]), .addr(addr[0]), .size(size[0]),
        .wdata(wdata[0]), .rdata(rdata[0]), .ready(ready[0]), .err(err[0])
    );

    dmem_responder #(.DEPTH_WORDS(Depth), .WAIT_STATES(3)) dut1 (
        .clk(clk), .reset(reset), .req(req[1]), .we(we[1]), .addr(addr[1]), .size(size[1]),
        .wdata(wdata[1]), .rdata(rdata[1]), .ready(ready[1]), .err(err[1])
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nVec = 0;
    int nErr = 0;

    // Model state: byte memory per instance, expected response cycle and data.
    logic [7:0]  mm [int];
    int          respCyc     [2] = '{-1, -1};
    int          lastRespCyc [2] = '{-10, -10};
    logic        pendErr     [2] = '{1'b0, 1'b0};
    logic [31:0] pendRd      [2] = '{32'd0, 32'd0};
    logic [31:0] holdRd      [2] = '{32'd0, 32'd0};

    function automatic int wsOf(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    function automatic int nBytes(input logic [1:0] sz);
        return (sz == 2'd1) ? 2 : (sz == 2'd2) ? 1 : 4;
    endfunction

    function automatic bit modelErr(input logic [31:0] a, input logic [1:0] sz);
        return (sz == 2'd1 && a[0]) || ((sz == 2'd0 || sz == 2'd3) && a[1:0] != 2'd0) ||
               (a[31:2] >= 30'(Depth));
    endfunction

    function automatic logic [31:0] modelLoad(input int i, input logic [31:0] a,
                                              input logic [1:0] sz);
        logic [31:0] r = 32'd0;
        for (int k = 0; k < nBytes(sz); k++) begin
            r[8*k +: 8] = mm[i * 65536 + int'(a) + k];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Per-cycle compare of both instances against the model.
    logic        eRdy, eErr;
    logic [31:0] eRd;
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (cyc == respCyc[i]) begin
                eRdy      = 1'b1;
                eErr      = pendErr[i];
                eRd       = pendRd[i];
                holdRd[i] = pendRd[i];
            end else begin
                eRdy = 1'b0;
                eErr = 1'b0;
                eRd  = holdRd[i];
            end
            check($sformatf("ready[%0d] cyc %0d", i, cyc), 32'(ready[i]), 32'(eRdy));
            check($sformatf("err[%0d] cyc %0d", i, cyc), 32'(err[i]), 32'(eErr));
            check($sformatf("rdata[%0d] cyc %0d", i, cyc), rdata[i], eRd);
        end
    end

    // One transaction; returns response err/rdata and measured accept-to-ready latency.
    task automatic txn(input int i, input bit w, input logic [31:0] a, input logic [1:0] sz,
                       input logic [31:0] wd, input bit holdReq,
                       output logic gotErr, output logic [31:0] gotRd, output int lat);
        int  acc;
        bit  seen = 1'b0;
        req[i] = 1'b1; we[i] = w; addr[i] = a; size[i] = sz; wdata[i] = wd;
        @(posedge clk); #1;
        // The edge leaving RESP never accepts; acceptance happens on the next one.
        if (cyc == lastRespCyc[i] + 1) begin
            @(posedge clk); #1;
        end
        acc        = cyc;
        pendErr[i] = modelErr(a, sz);
        pendRd[i]  = (w || pendErr[i]) ? 32'd0 : modelLoad(i, a, sz);
        respCyc[i] = acc + wsOf(i);
        if (ready[i]) seen = 1'b1;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(posedge clk); #1;
            if (ready[i]) seen = 1'b1;
        end
        if (!seen) begin
            nVec++;
            nErr++;
            $display("FAIL ready timeout inst %0d addr %h: got none, expected a pulse", i, a);
        end
        lat = cyc - acc;
        @(negedge clk);
        gotErr         = err[i];
        gotRd          = rdata[i];
        lastRespCyc[i] = respCyc[i];
        if (w && !pendErr[i]) begin
            for (int k = 0; k < nBytes(sz); k++) mm[i * 65536 + int'(a) + k] = wd[8*k +: 8];
        end
        req[i] = holdReq;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "watchdog");
    end

    logic        e;
    logic [31:0] r;
    int          lat;

    initial begin
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; addr[i] = 32'd0; size[i] = 2'd0; wdata[i] = 32'd0;
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset ready[%0d]", i), 32'(ready[i]), 32'd0);
            check($sformatf("reset rdata[%0d]", i), rdata[i], 32'd0);
        end

        // Zero wait states: word, byte and half lanes.
        txn(0, 1, 32'h10, 2'd0, 32'hDEADBEEF, 0, e, r, lat);
        check("st word err", 32'(e), 32'd0);
        check("st word latency", 32'(lat), 32'd0);
        txn(0, 0, 32'h10, 2'd0, 32'h0, 0, e, r, lat);
        check("ld word 0x10", r, 32'hDEADBEEF);
        txn(0, 1, 32'h10, 2'd0, 32'h0, 0, e, r, lat);
        txn(0, 1, 32'h13, 2'd2, 32'h123456AB, 0, e, r, lat);
        txn(0, 1, 32'h10, 2'd1, 32'hCAFE1234, 0, e, r, lat);
        txn(0, 0, 32'h10, 2'd0, 32'h0, 0, e, r, lat);
        check("ld word lanes", r, 32'hAB001234);
        txn(0, 0, 32'h13, 2'd2, 32'h0, 0, e, r, lat);
        check("ld byte 0x13", r, 32'h000000AB);
        txn(0, 0, 32'h12, 2'd1, 32'h0, 0, e, r, lat);
        check("ld half 0x12", r, 32'h0000AB00);
        txn(0, 0, 32'h11, 2'd2, 32'h0, 0, e, r, lat);
        check("ld byte 0x11", r, 32'h00000012);
        txn(0, 0, 32'h10, 2'd3, 32'h0, 0, e, r, lat);
        check("ld size3 word", r, 32'hAB001234);

        // Errors: misaligned half store, out-of-range load, misaligned word load.
        txn(0, 1, 32'h20, 2'd0, 32'h55667788, 0, e, r, lat);
        txn(0, 1, 32'h21, 2'd1, 32'hFFFFFFFF, 0, e, r, lat);
        check("st half 0x21 err", 32'(e), 32'd1);
        check("st half 0x21 rdata", r, 32'd0);
        txn(0, 0, 32'h20, 2'd0, 32'h0, 0, e, r, lat);
        check("ld 0x20 unchanged", r, 32'h55667788);
        txn(0, 0, Depth * 4, 2'd0, 32'h0, 0, e, r, lat);
        check("ld range err", 32'(e), 32'd1);
        check("ld range rdata", r, 32'd0);
        txn(0, 0, 32'h12, 2'd0, 32'h0, 0, e, r, lat);
        check("ld word misalign err", 32'(e), 32'd1);

        // Back-to-back with req held through RESP.
        txn(0, 0, 32'h10, 2'd1, 32'h0, 1, e, r, lat);
        check("b2b first", r, 32'h00001234);
        txn(0, 0, 32'h13, 2'd2, 32'h0, 0, e, r, lat);
        check("b2b second", r, 32'h000000AB);

        // Three wait states.
        txn(1, 1, 32'h40, 2'd0, 32'h11223344, 0, e, r, lat);
        check("ws3 store latency", 32'(lat), 32'd3);
        txn(1, 0, 32'h40, 2'd0, 32'h0, 1, e, r, lat);
        check("ws3 load", r, 32'h11223344);
        check("ws3 load latency", 32'(lat), 32'd3);
        txn(1, 0, 32'h42, 2'd1, 32'h0, 0, e, r, lat);
        check("ws3 b2b half", r, 32'h00001122);

        // Reset during WAIT drops the pending store.
        txn(1, 0, 32'h40, 2'd0, 32'h0, 0, e, r, lat);
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h40; size[1] = 2'd0; wdata[1] = 32'h99999999;
        @(posedge clk); #1;
        if (cyc == lastRespCyc[1] + 1) begin
            @(posedge clk); #1;
        end
        #2;
        reset      = 1'b1;
        respCyc    = '{-1, -1};
        holdRd     = '{32'd0, 32'd0};
        req[1]     = 1'b0;
        #1;
        check("async reset ready", 32'(ready[1]), 32'd0);
        check("async reset err", 32'(err[1]), 32'd0);
        check("async reset rdata", rdata[1], 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        txn(1, 0, 32'h40, 2'd0, 32'h0, 0, e, r, lat);
        check("post reset old data", r, 32'h11223344);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined RISC-V core: the slave end of the MEM-stage load/store interface. It accepts one word/half/byte request at a time from the datapath. It steers store data from the low lanes into the addressed byte lanes with a byte mask, and returns load data right-justified into bits [15:0]/[7:0] for the core's sign/zero extension. A configurable wait-state count and a req/ready handshake let the core's stall logic hold the MEM stage.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the internal array; word index = addr[31:2].
- WAIT_STATES, 0: extra cycles inserted between request acceptance and response (0..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  request valid; held high with all request inputs stable until ready.
- we  input  1  1 = store, 0 = load.
- addr  input  32  byte address.
- size  input  2  00 word, 01 halfword, 10 byte, 11 treated as word.
- wdata  input  32  store data; half in [15:0], byte in [7:0], upper bits ignored for sub-word.
- rdata  output  32  load data, right-justified, upper bits zero for sub-word.
- ready  output  1  one-cycle response strobe; transaction complete.
- err  output  1  valid with ready; misaligned or out-of-range access.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req=1 sampled at an edge → WAIT (counter loaded with WAIT_STATES-1) if WAIT_STATES>0, else RESP. Request fields are latched at that edge.
- WAIT: counter decrements each edge; at 0 → RESP.
- RESP: ready=1 for exactly this cycle. req is ignored in RESP. Next edge → IDLE.
- Throughput: one transaction per WAIT_STATES+2 cycles minimum.
- Error check: half with addr[0]=1, word with addr[1:0]≠0, or addr[31:2] ≥ DEPTH_WORDS → err=1 in RESP. Stores are dropped. Loads return rdata=0.
- Byte lanes are set by latched addr[1:0]:
  - word: mask 1111.
  - half: mask 0011 at offset 0, 1100 at offset 2.
  - byte: mask = 1 << addr[1:0].
- Store: wdata[15:0] or wdata[7:0] is replicated/shifted into the selected lanes. Only masked bytes are written, at the edge leaving RESP.
- Load: the word is read and shifted right by 8*addr[1:0], then masked to 16/8 bits. rdata is registered on the edge entering RESP.
- rdata holds its last value until the next load response. After a store or error response rdata = 0.
- Array contents are not reset and are undefined until written.

## Timing
- Request first sampled at edge N → ready high during cycle N+1+WAIT_STATES (WAIT_STATES=0: ready in the cycle right after acceptance).
- Store data is visible to a load accepted at any later edge. There is no internal read-after-write hazard, because transactions are serialized.
- Reset (asynchronous, any state):
  - state → IDLE; ready=0, err=0, rdata=0; counter = 0.
  - A pending store is not committed.
- req deasserted mid-WAIT (protocol violation): the transaction still completes using the latched fields.
- ready and err are registered outputs (decoded from state/flags), glitch-free.

## Test plan
- Word store/load, WAIT_STATES=0: store addr 0x10 data 0xDEADBEEF → ready 1 cycle after accept, err=0. Load 0x10 → rdata 0xDEADBEEF.
- Byte/half lanes: store byte 0xAB to 0x13, then half 0x1234 to 0x10. Word load 0x10 → 0xAB001234 (after the first word 0x00000000). Byte load 0x13 → 0x000000AB. Half load 0x12 → 0x0000AB00.
- Wait states, WAIT_STATES=3: load accepted at edge N → ready high only in cycle N+4, low in cycles N+1..N+3. Next request accepted no earlier than edge N+5.
- Errors:
  - half store to 0x21 → err=1 and memory at 0x20 unchanged.
  - word load at DEPTH_WORDS*4 → err=1, rdata=0.
- Reset mid-transaction: store accepted with WAIT_STATES=3, reset asserted asynchronously in WAIT → ready/err/rdata = 0 immediately. A subsequent load of that address shows the old contents.
- Back-to-back: req held high through RESP → exactly one ready pulse. A new transaction is accepted only from IDLE on the following edge.
